melody_seq: RTL

Score sequencer that sits directly upstream of the buzzer tone generator. It walks an internal 16-entry score ROM of (note, beats) entries and presents, for each note in turn, the 18-bit half-period divider value, a tone enable and a one-cycle load strobe. The tone generator consumes these and toggles the buzzer pin. Playback supports start, stop, rests, a short articulation gap between notes, and optional looping.

---
 rtl/melody_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/melody_seq.sv
// Score sequencer: walks a 16-entry (note, beats) ROM and feeds divider value,
// tone enable and a one-cycle load strobe to the downstream buzzer tone generator.
module melody_seq #(
    parameter logic [24:0] TICK_CNT = 25'd12499999,
    parameter logic [24:0] GAP_CNT  = 25'd2499999,
    parameter logic        LOOP     = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        stop,
    output logic [17:0] tone_div,
    output logic        tone_en,
    output logic        tone_load,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    localparam logic [17:0] DIV_DO = 18'd190839;

    state_t      state, state_nx;
    logic [24:0] tick_cnt, tick_nx;
    logic [24:0] gap_cnt, gap_nx;
    logic [2:0]  beats_left, beats_nx;
    logic [17:0] div_nx;
    logic        en_nx, load_nx, done_nx, busy_nx;
    logic [3:0]  idx_nx;

    logic [6:0]  entry;
    logic [3:0]  entry_note;
    logic [2:0]  entry_beats;
    logic [17:0] entry_div;
    logic        entry_tone;

    // Score: rising scale at 2 beats, a 1-beat rest, falling scale at 1 beat, end marker.
    always_comb begin
        case (note_idx)
            4'd0:    entry = {4'd1, 3'd2};
            4'd1:    entry = {4'd2, 3'd2};
            4'd2:    entry = {4'd3, 3'd2};
            4'd3:    entry = {4'd4, 3'd2};
            4'd4:    entry = {4'd5, 3'd2};
            4'd5:    entry = {4'd6, 3'd2};
            4'd6:    entry = {4'd7, 3'd2};
            4'd7:    entry = {4'd0, 3'd1};
            4'd8:    entry = {4'd7, 3'd1};
            4'd9:    entry = {4'd6, 3'd1};
            4'd10:   entry = {4'd5, 3'd1};
            4'd11:   entry = {4'd4, 3'd1};
            4'd12:   entry = {4'd3, 3'd1};
            4'd13:   entry = {4'd2, 3'd1};
            4'd14:   entry = {4'd1, 3'd1};
            default: entry = {4'd0, 3'd0};
        endcase
    end

    assign entry_note  = entry[6:3];
    assign entry_beats = entry[2:0];

    always_comb begin
        entry_div  = DIV_DO;
        entry_tone = 1'b1;
        case (entry_note)
            4'd1:    entry_div = 18'd190839;
            4'd2:    entry_div = 18'd170067;
            4'd3:    entry_div = 18'd151514;
            4'd4:    entry_div = 18'd143265;
            4'd5:    entry_div = 18'd127550;
            4'd6:    entry_div = 18'd113635;
            4'd7:    entry_div = 18'd101214;
            default: entry_tone = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx = state;
        tick_nx  = tick_cnt;
        gap_nx   = gap_cnt;
        beats_nx = beats_left;
        div_nx   = tone_div;
        en_nx    = tone_en;
        idx_nx   = note_idx;
        load_nx  = 1'b0;
        done_nx  = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            tick_nx  = '0;
            gap_nx   = '0;
            beats_nx = '0;
            en_nx    = 1'b0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    en_nx  = 1'b0;
                    idx_nx = '0;
                    if (start) state_nx = LOAD;
                end
                LOAD: begin
                    if (entry_beats != 3'd0) begin
                        // A rest keeps the previous divider so the tone generator sees no glitch.
                        if (entry_tone) div_nx = entry_div;
                        en_nx    = entry_tone;
                        load_nx  = 1'b1;
                        beats_nx = entry_beats;
                        tick_nx  = '0;
                        state_nx = PLAY;
                    end else if (LOOP && (note_idx != 4'd0)) begin
                        idx_nx = '0;
                    end else begin
                        done_nx  = 1'b1;
                        en_nx    = 1'b0;
                        idx_nx   = '0;
                        state_nx = IDLE;
                    end
                end
                PLAY: begin
                    if (tick_cnt == TICK_CNT) begin
                        tick_nx  = '0;
                        beats_nx = beats_left - 3'd1;
                        if (beats_left == 3'd1) begin
                            en_nx    = 1'b0;
                            gap_nx   = '0;
                            state_nx = GAP;
                        end
                    end else begin
                        tick_nx = tick_cnt + 25'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_CNT) begin
                        gap_nx   = '0;
                        idx_nx   = note_idx + 4'd1;
                        state_nx = LOAD;
                    end else begin
                        gap_nx = gap_cnt + 25'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy_nx = (state_nx != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            gap_cnt    <= '0;
            beats_left <= '0;
            tone_div   <= DIV_DO;
            tone_en    <= 1'b0;
            tone_load  <= 1'b0;
            note_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            tick_cnt   <= tick_nx;
            gap_cnt    <= gap_nx;
            beats_left <= beats_nx;
            tone_div   <= div_nx;
            tone_en    <= en_nx;
            tone_load  <= load_nx;
            note_idx   <= idx_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end
endmodule
